// File: rtl/monitor_pkg.sv
// Shared types and default constants for the output signature monitor.
package monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } mon_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; clear loads SEED and wins over en.
module misr16
    import monitor_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter logic [15:0] POLY = DEFAULT_POLY,
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [15:0]   sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ 16'(data);
        end
    end

    always_ff @(posedge clk) begin
        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/output_signature_monitor.sv
// Captures a programmable window of netlist outputs into a MISR signature,
// counting output changes and recording the index of the first change.
module output_signature_monitor
    import monitor_pkg::*;
#(
    parameter int unsigned WIDTH         = 15,
    parameter int unsigned CYC_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] POLY          = DEFAULT_POLY,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input  logic             bertaClock,
    input  logic             global_reset,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             start,
    input  logic [CYC_W-1:0] capture_len,
    output logic             busy,
    output logic             done,
    output logic [15:0]      sig,
    output logic [CYC_W-1:0] change_count,
    output logic             first_change_valid,
    output logic [CYC_W-1:0] first_change_idx
);

    mon_state_t       state_q, state_d;
    logic [CYC_W-1:0] len_q, len_d;
    logic [CYC_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CYC_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CYC_W-1:0] change_count_q, change_count_d;
    logic             fc_valid_q, fc_valid_d;
    logic [CYC_W-1:0] fc_idx_q, fc_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             misr_clear_c;
    logic             misr_en_c;

    // Next-state, counters and change detection.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        settle_cnt_d   = settle_cnt_q;
        idx_d          = idx_q;
        prev_d         = prev_q;
        change_count_d = change_count_q;
        fc_valid_d     = fc_valid_q;
        fc_idx_d       = fc_idx_q;
        misr_clear_c   = 1'b0;
        misr_en_c      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = SETTLE;
                    len_d          = capture_len;
                    settle_cnt_d   = '0;
                    idx_d          = '0;
                    change_count_d = '0;
                    fc_valid_d     = 1'b0;
                    fc_idx_d       = '0;
                    misr_clear_c   = 1'b1;
                end
            end
            SETTLE: begin
                prev_d       = dut_out;
                settle_cnt_d = settle_cnt_q + CYC_W'(1);
                if (settle_cnt_q == CYC_W'(SETTLE_CYCLES - 1)) begin
                    state_d = (len_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                misr_en_c = 1'b1;
                if (dut_out != prev_q) begin
                    if (change_count_q != '1) begin
                        change_count_d = change_count_q + CYC_W'(1);
                    end
                    if (!fc_valid_q) begin
                        fc_valid_d = 1'b1;
                        fc_idx_d   = idx_q;
                    end
                end
                prev_d = dut_out;
                idx_d  = idx_q + CYC_W'(1);
                if (idx_q == len_q - CYC_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SETTLE) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge bertaClock) begin
        if (global_reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            settle_cnt_q   <= '0;
            idx_q          <= '0;
            prev_q         <= '0;
            change_count_q <= '0;
            fc_valid_q     <= 1'b0;
            fc_idx_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            settle_cnt_q   <= settle_cnt_d;
            idx_q          <= idx_d;
            prev_q         <= prev_d;
            change_count_q <= change_count_d;
            fc_valid_q     <= fc_valid_d;
            fc_idx_q       <= fc_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Reset shares the seed-load path so the signature returns to SEED with everything else.
    misr16 #(
        .DW   (WIDTH),
        .POLY (POLY),
        .SEED (SEED)
    ) u_misr (
        .clk   (bertaClock),
        .clear (global_reset | misr_clear_c),
        .en    (misr_en_c),
        .data  (dut_out),
        .sig   (sig)
    );

    assign busy               = busy_q;
    assign done               = done_q;
    assign change_count       = change_count_q;
    assign first_change_valid = fc_valid_q;
    assign first_change_idx   = fc_idx_q;

endmodule

// File: tb/tb_output_signature_monitor.sv
// Randomized scoreboard bench for output_signature_monitor against a window-level model.
module tb_output_signature_monitor;

    localparam int unsigned WIDTH  = 15;
    localparam int unsigned CYC_W  = 16;
    localparam int unsigned SETTLE = 2;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] SEED   = 16'h0000;

    logic             clk = 1'b0;
    logic             global_reset = 1'b1;
    logic [WIDTH-1:0] dut_out = '0;
    logic             start = 1'b0;
    logic [CYC_W-1:0] capture_len = '0;
    logic             busy, done;
    logic [15:0]      sig;
    logic [CYC_W-1:0] change_count;
    logic             first_change_valid;
    logic [CYC_W-1:0] first_change_idx;

    output_signature_monitor #(
        .WIDTH(WIDTH), .CYC_W(CYC_W), .SETTLE_CYCLES(SETTLE), .POLY(POLY), .SEED(SEED)
    ) dut (
        .bertaClock(clk), .global_reset(global_reset), .dut_out(dut_out),
        .start(start), .capture_len(capture_len), .busy(busy), .done(done),
        .sig(sig), .change_count(change_count),
        .first_change_valid(first_change_valid), .first_change_idx(first_change_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cc;
        logic        fcv;
        logic [15:0] fci;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] smp [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Window result from the rules: polynomial MISR over samples, change count vs previous sample.
    function automatic exp_t model(input int len, input logic [WIDTH-1:0] last_settle, input int k);
        exp_t e;
        logic [15:0] s;
        logic [WIDTH-1:0] pv;
        s = SEED;
        pv = last_settle;
        e.cc = 0; e.fcv = 0; e.fci = 0;
        for (int i = 0; i < len; i++) begin
            logic [15:0] fb;
            fb = (s >= 16'h8000) ? POLY : 16'h0000;
            s = 16'((32'(s) * 2) % 65536) ^ fb ^ 16'(smp[i]);
            if (smp[i] != pv) begin
                if (e.cc != 16'hFFFF) e.cc = e.cc + 16'd1;
                if (!e.fcv) begin
                    e.fcv = 1'b1;
                    e.fci = 16'(i);
                end
            end
            pv = smp[i];
        end
        e.sig = s;
        e.done_cyc = k + int'(SETTLE) + len;
        return e;
    endfunction

    // Runs one capture window from an idle/done state; data comes from smp[].
    task automatic run_window(input int len, input logic [WIDTH-1:0] last_settle, input bit mid_start);
        int k;
        int waited;
        k = cyc + 1;
        sb.push_back(model(len, last_settle, k));
        start = 1'b1;
        capture_len = 16'(len);
        dut_out = WIDTH'($urandom);
        @(negedge clk);
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_done", {31'b0, done}, 32'd0);
        check("start_sig_clear", {16'b0, sig}, {16'b0, SEED});
        check("start_cc_clear", {16'b0, change_count}, 32'd0);
        check("start_fcv_clear", {31'b0, first_change_valid}, 32'd0);
        check("start_fci_clear", {16'b0, first_change_idx}, 32'd0);
        start = 1'b0;
        for (int j = 0; j < int'(SETTLE); j++) begin
            capture_len = 16'($urandom);
            dut_out = (j == int'(SETTLE) - 1) ? last_settle : WIDTH'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < len; i++) begin
            dut_out = smp[i];
            start = mid_start && (i == len / 2);
            capture_len = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        waited = 0;
        while (!done && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
            sb.delete();
        end
        repeat ($urandom_range(0, 3)) begin
            dut_out = WIDTH'($urandom);
            @(negedge clk);
        end
    endtask

    // Monitor: compares completed-window results whenever done is presented.
    logic done_prev = 1'b0;
    bit   have_cur = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (global_reset) begin
            have_cur = 0;
        end else if (done && !done_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                cur = sb.pop_front();
                have_cur = 1;
                check("done_cycle", 32'(cyc), 32'(cur.done_cyc));
                check("done_busy", {31'b0, busy}, 32'd0);
                check("sig", {16'b0, sig}, {16'b0, cur.sig});
                check("change_count", {16'b0, change_count}, {16'b0, cur.cc});
                check("first_change_valid", {31'b0, first_change_valid}, {31'b0, cur.fcv});
                check("first_change_idx", {16'b0, first_change_idx}, {16'b0, cur.fci});
            end
        end else if (done && have_cur) begin
            check("hold_sig", {16'b0, sig}, {16'b0, cur.sig});
            check("hold_cc", {16'b0, change_count}, {16'b0, cur.cc});
        end
        if (!done) have_cur = 0;
        done_prev = done;
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_sig"}, {16'b0, sig}, {16'b0, SEED});
        check({tag, "_cc"}, {16'b0, change_count}, 32'd0);
        check({tag, "_fcv"}, {31'b0, first_change_valid}, 32'd0);
        check({tag, "_fci"}, {16'b0, first_change_idx}, 32'd0);
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        global_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) smp[i] = '0;
        run_window(4, '0, 0);

        smp[0] = 15'd1; smp[1] = '0; smp[2] = '0;
        run_window(3, '0, 0);

        for (int i = 0; i < 8; i++) smp[i] = (i % 2 == 0) ? 15'd1 : 15'd0;
        run_window(8, '0, 0);

        smp[0] = 15'h4000; smp[1] = 15'h4000;
        run_window(2, 15'h4000, 1);

        run_window(0, WIDTH'($urandom), 0);

        // Reset coincident with start in the middle of a run.
        start = 1'b1;
        capture_len = 16'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (int'(SETTLE) + 3) begin
            dut_out = WIDTH'($urandom);
            @(negedge clk);
        end
        global_reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_values("midrun_reset");
        global_reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle_busy", {31'b0, busy}, 32'd0);
        check("post_reset_idle_done", {31'b0, done}, 32'd0);

        for (int w = 0; w < 30; w++) begin
            int len;
            len = $urandom_range(0, 24);
            for (int i = 0; i < len; i++) begin
                smp[i] = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : ((i > 0) ? smp[i-1] : '0);
            end
            run_window(len, ($urandom_range(0, 1) == 0) ? '0 : WIDTH'($urandom), $urandom_range(0, 1) == 1);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
